// File: rtl/msk_and_ghpc_arb.sv
// ---------------------------------------------------------------------------
// msk_and_ghpc_arb
//   Two requesters share one 2-share masked AND gadget (GHPC-style, one fresh
//   random bit per operation, two register stages). Requests are arbitrated
//   round-robin. Results are queued in order in a small FIFO tagged with the
//   requester index.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   req_valid[1:0]      request strobe per requester
//   req_ready[1:0]      grant / accept per requester (one-hot or zero)
//   req_ina/req_inb     2-share operands, [2i+1:2i] belongs to requester i
//   rnd_valid, rnd      fresh random bit
//   rnd_ready           random bit consumed (accept strobe)
//   res_valid/res_ready result FIFO handshake
//   res_out[1:0]        2-share AND result of the head entry
//   res_id              requester index of the head entry
//   busy                operation in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module msk_and_ghpc_arb #(
    parameter int DEPTH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_ina,
    input  logic [3:0] req_inb,
    input  logic       rnd_valid,
    input  logic       rnd,
    output logic       rnd_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [1:0] res_out,
    output logic       res_id,
    output logic       busy
);

    generate
        if (DEPTH < 4 || DEPTH > 8) begin : g_bad_depth
            $error("msk_and_ghpc_arb: DEPTH must be in 4..8");
        end
    endgenerate

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // pipeline valids: v0 = operand regs, v1 = gadget stage 1, v2 = gadget stage 2
    logic          v0, v1, v2;
    logic          id0, id1, id2;
    logic          pri;            // requester favoured on contention
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wptr, rptr;

    logic [3:0]    occ;
    logic          space;
    logic [1:0]    grant;
    logic          accept;
    logic          accept_id;
    logic          push, pop;

    // share-separated operand registers
    logic          op_a0, op_a1, op_b0, op_b1, op_r;
    // gadget stage 1 and stage 2 registers
    logic          t00, t01, t10, t11;
    logic          c0, c1;

    logic [1:0]    mem_d  [DEPTH];
    logic          mem_id [DEPTH];

    // Room is reserved for every in-flight operation so the FIFO can never
    // overflow; a same-cycle pop is deliberately not credited.
    always_comb begin
        occ   = 4'(fifo_count) + {3'b000, v0} + {3'b000, v1} + {3'b000, v2};
        space = (occ + 4'd1) <= 4'(DEPTH);
        grant = 2'b00;
        if (rst_n && rnd_valid && space) begin
            if (req_valid == 2'b11) begin
                grant = pri ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign accept_id = grant[1];
    assign rnd_ready = accept;

    assign push      = v2;
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid & res_ready;
    assign busy      = v0 | v1 | v2 | res_valid;

    // gated so the outputs read zero while the FIFO is empty (and in reset)
    assign res_out   = res_valid ? mem_d[rptr]  : 2'b00;
    assign res_id    = res_valid ? mem_id[rptr] : 1'b0;

    // control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0         <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            pri        <= 1'b0;
            fifo_count <= '0;
            wptr       <= '0;
            rptr       <= '0;
        end else begin
            v0 <= accept;
            v1 <= v0;
            v2 <= v1;
            if (accept) begin
                pri <= ~accept_id;
            end
            if (push) begin
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // datapath: no reset needed, validity is carried by v0..v2 and fifo_count
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a0 <= accept_id ? req_ina[2] : req_ina[0];
            op_a1 <= accept_id ? req_ina[3] : req_ina[1];
            op_b0 <= accept_id ? req_inb[2] : req_inb[0];
            op_b1 <= accept_id ? req_inb[3] : req_inb[1];
            op_r  <= rnd;
        end
        id0 <= accept_id;
        id1 <= id0;
        id2 <= id1;

        // cross products are refreshed by r before being combined with the
        // same-index product, so no register ever holds both shares of a value
        t00 <= op_a0 & op_b0;
        t01 <= (op_a0 & op_b1) ^ op_r;
        t10 <= (op_a1 & op_b0) ^ op_r;
        t11 <= op_a1 & op_b1;
        c0  <= t00 ^ t01;
        c1  <= t11 ^ t10;

        if (push) begin
            mem_d[wptr]  <= {c1, c0};
            mem_id[wptr] <= id2;
        end
    end

endmodule

// File: tb/tb_msk_and_ghpc_arb.sv
// ---------------------------------------------------------------------------
// tb_msk_and_ghpc_arb
//   Directed scenarios plus a random sweep for msk_and_ghpc_arb. Inputs are
//   driven on the falling edge and outputs sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_msk_and_ghpc_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_ina;
    logic [3:0] req_inb;
    logic       rnd_valid;
    logic       rnd;
    logic       rnd_ready;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_out;
    logic       res_id;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msk_and_ghpc_arb #(.DEPTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ina   (req_ina),
        .req_inb   (req_inb),
        .rnd_valid (rnd_valid),
        .rnd       (rnd),
        .rnd_ready (rnd_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .res_id    (res_id),
        .busy      (busy)
    );

    task automatic idle_inputs();
        req_valid = 2'b00;
        req_ina   = 4'b0000;
        req_inb   = 4'b0000;
        rnd_valid = 1'b0;
        rnd       = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // requester 0: A xor 1, B xor 1 -> 1 ; requester 1: A xor 1, B xor 0 -> 0
    task automatic fixed_ops();
        req_ina = 4'b1001;
        req_inb = 4'b0010;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_ina   = 4'b1111;
        req_inb   = 4'b1111;
        rnd_valid = 1'b1;
        rnd       = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 2'b00 || rnd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant req_ready=%b rnd_ready=%b want 00/0", req_ready, rnd_ready);
        end
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_out !== 2'b00 || res_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs res_valid=%b busy=%b res_out=%b res_id=%b want all 0",
                     res_valid, busy, res_out, res_id);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        req_valid = 2'b01;
        req_ina   = 4'b0001;
        req_inb   = 4'b0010;
        rnd_valid = 1'b1;
        rnd       = 1'b1;
        res_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01 || rnd_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_accept req_ready=%b rnd_ready=%b want 01/1", req_ready, rnd_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL single_latency k=%0d res_valid=%b busy=%b want 0/1", k, res_valid, busy);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        total++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || (^res_out) !== 1'b1) begin
            bad++;
            $display("FAIL single_result res_valid=%b res_id=%b xor=%b want 1/0/1",
                     res_valid, res_id, ^res_out);
        end
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_drain res_valid=%b busy=%b want 0/0", res_valid, busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        logic       exp_id;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = 2'b11;
            fixed_ops();
            rnd_valid = 1'b1;
            rnd       = 1'($urandom);
            res_ready = 1'b1;
            exp_g     = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total++;
            if (req_ready !== exp_g) begin
                bad++;
                $display("FAIL contention_grant k=%0d got=%b want=%b", k, req_ready, exp_g);
            end
        end
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            req_valid = 2'b00;
            rnd_valid = 1'b0;
            exp_id    = ((k - 4) % 2 == 1);
            #1;
            total++;
            if (res_valid !== 1'b1 || res_id !== exp_id || (^res_out) !== ~exp_id) begin
                bad++;
                $display("FAIL contention_result k=%0d valid=%b id=%b xor=%b want 1/%b/%b",
                         k, res_valid, res_id, ^res_out, exp_id, ~exp_id);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL contention_empty res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 2'b01;
            fixed_ops();
            rnd_valid = 1'b0;
            res_ready = 1'b1;
            #1;
            total++;
            if (req_ready !== 2'b00 || rnd_ready !== 1'b0) begin
                bad++;
                $display("FAIL starve_hold k=%0d req_ready=%b rnd_ready=%b want 00/0", k, req_ready, rnd_ready);
            end
        end
        @(negedge clk);
        rnd_valid = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01 || rnd_ready !== 1'b1) begin
            bad++;
            $display("FAIL starve_release req_ready=%b rnd_ready=%b want 01/1", req_ready, rnd_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rnd_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_g;
        int         popped;
        logic       exp_id;
        logic [1:0] p2 [4];
        p2[0] = 2'b00; p2[1] = 2'b10; p2[2] = 2'b01; p2[3] = 2'b10;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = 2'b11;
            fixed_ops();
            rnd_valid = 1'b1;
            rnd       = 1'($urandom);
            res_ready = 1'b0;
            exp_g     = (k >= 5) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            #1;
            total++;
            if (req_ready !== exp_g) begin
                bad++;
                $display("FAIL bp_fill k=%0d got=%b want=%b", k, req_ready, exp_g);
            end
        end
        popped = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            res_ready = 1'b1;
            req_valid = (k < 4) ? 2'b11 : 2'b00;
            #1;
            if (k < 4) begin
                total++;
                if (req_ready !== p2[k]) begin
                    bad++;
                    $display("FAIL bp_resume k=%0d got=%b want=%b", k, req_ready, p2[k]);
                end
            end
            if (res_valid) begin
                exp_id = (popped % 2 == 1);
                total++;
                if (res_id !== exp_id || (^res_out) !== ~exp_id) begin
                    bad++;
                    $display("FAIL bp_order n=%0d id=%b xor=%b want %b/%b",
                             popped, res_id, ^res_out, exp_id, ~exp_id);
                end
                popped++;
            end
        end
        total++;
        if (popped != 8) begin
            bad++;
            $display("FAIL bp_count got=%0d want=8", popped);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 2'b11;
            fixed_ops();
            rnd_valid = 1'b1;
            res_ready = 1'b0;
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b00 || rnd_ready !== 1'b0 || res_valid !== 1'b0 ||
            busy !== 1'b0 || res_out !== 2'b00 || res_id !== 1'b0) begin
            bad++;
            $display("FAIL midrst_during rr=%b rnd=%b rv=%b busy=%b out=%b id=%b want all 0",
                     req_ready, rnd_ready, res_valid, busy, res_out, res_id);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midrst_after k=%0d res_valid=%b busy=%b want 0/0", k, res_valid, busy);
            end
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL midrst_first_grant got=%b want=01", req_ready);
        end
        @(negedge clk);
        idle_inputs();
        res_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0] exp_q [$];
        logic [1:0] e;
        logic [1:0] pa, pb;
        int         acc;
        int         cyc;
        int         id;
        acc = 0;
        cyc = 0;
        apply_reset();
        while ((acc < 10000 || exp_q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (acc < 10000) begin
                req_valid = 2'($urandom);
                rnd_valid = ($urandom_range(0, 9) != 0);
            end else begin
                req_valid = 2'b00;
                rnd_valid = 1'b0;
            end
            req_ina   = 4'($urandom);
            req_inb   = 4'($urandom);
            rnd       = 1'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (rnd_ready !== (|req_ready) || req_ready === 2'b11 ||
                (req_ready & ~req_valid) !== 2'b00 || (!rnd_valid && req_ready !== 2'b00)) begin
                bad++;
                $display("FAIL rand_grant cyc=%0d req_valid=%b rnd_valid=%b req_ready=%b rnd_ready=%b",
                         cyc, req_valid, rnd_valid, req_ready, rnd_ready);
            end
            if (req_ready == 2'b01 || req_ready == 2'b10) begin
                id = req_ready[1] ? 1 : 0;
                pa = req_ina[2*id +: 2];
                pb = req_inb[2*id +: 2];
                exp_q.push_back({1'(id), (^pa) & (^pb)});
                acc++;
            end
            if (res_valid && res_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra id=%b xor=%b want no result", res_id, ^res_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({res_id, ^res_out} !== e) begin
                        bad++;
                        $display("FAIL rand_result cyc=%0d id/xor=%b%b want %b", cyc, res_id, ^res_out, e);
                    end
                end
            end
        end
        total++;
        if (cyc >= 60000) begin
            bad++;
            $display("FAIL rand_timeout accepts=%0d pending=%0d want 10000/0", acc, exp_q.size());
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rand_final res_valid=%b busy=%b want 0/0", res_valid, busy);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_starvation();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msk_and_ghpc_arb.md
MSK_AND_GHPC_ARB -- requirements
Module: msk_and_ghpc_arb

Interface
REQ-001 Parameter: DEPTH, 5, result FIFO entries; legal range 4..8, other values SHALL fail elaboration.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
REQ-004 req_valid  in  2  per-requester request strobe; bit i = requester i.
REQ-005 req_ready  out  2  per-requester grant; at most one bit high per cycle.
REQ-006 req_ina  in  4  operand A sharings; [2i+1:2i] = 2-share A of requester i.
REQ-007 req_inb  in  4  operand B sharings; same packing as req_ina.
REQ-008 rnd_valid  in  1  fresh random bit available.
REQ-009 rnd  in  1  random bit.
REQ-010 rnd_ready  out  1  random bit consumed this cycle.
REQ-011 res_valid  out  1  result FIFO non-empty.
REQ-012 res_ready  in  1  consumer accepts the head result.
REQ-013 res_out  out  2  2-share masked AND result of the head entry.
REQ-014 res_id  out  1  requester index of the head entry.
REQ-015 busy  out  1  high while any operation is in flight or the FIFO is non-empty.

Function
REQ-016 The block SHALL contain one 2-share GHPC AND gadget (d=2, 1 random bit per operation, latency 2) shared between both requesters.
REQ-017 Accept in cycle t SHALL require: selected req_valid high, rnd_valid high, and (fifo_count + inflight + 1) <= DEPTH, with fifo_count and inflight taken as registered values and same-cycle pops ignored.
REQ-018 Arbitration SHALL be round-robin: on contention, grant the requester not granted at the last accept; when only one requests, grant it.
REQ-019 The round-robin pointer SHALL update only on accept.
REQ-020 rnd_ready SHALL equal the accept strobe (OR of req_ready); no random bit SHALL be consumed without an accept, and no bit SHALL be used for two operations.
REQ-021 On accept, operand shares, rnd and requester id SHALL be registered into share-separated operand registers; the gadget inputs SHALL be driven only from these registers, never from combinational muxes.
REQ-022 Operand registers SHALL hold their value when no accept occurs.
REQ-023 A 3-stage valid/id shift pipeline SHALL track operations; the result of an accept in cycle t SHALL be written to the FIFO at the end of cycle t+3, and res_valid SHALL be visible no earlier than cycle t+4.
REQ-024 The FIFO SHALL preserve accept order; res_out/res_id SHALL reflect the head entry; pop occurs when res_valid & res_ready.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-026 FIFO overflow SHALL be impossible by construction (REQ-017); underflow pops SHALL be ignored.
REQ-027 With res_ready held high and both inputs continuously valid, sustained throughput SHALL be one accept per cycle.
REQ-028 res_out SHALL equal a 2-share sharing whose XOR equals (XOR of A shares) AND (XOR of B shares).

Reset
REQ-029 During rst_n low: req_ready=00, rnd_ready=0, res_valid=0, busy=0, res_out=00, res_id=0.
REQ-030 Reset SHALL empty the FIFO, clear all pipeline valids (in-flight operations discarded, never emitted), and set the round-robin pointer to favour requester 0.
REQ-031 Operand and gadget data registers need not be reset.

Verification
REQ-032 Single op: requester 0 A=(1,0), B=(0,1), rnd_valid=1 at t -> req_ready=01 at t, res_valid at t+4, res_id=0, XOR(res_out)=1.
REQ-033 Contention: both req_valid high 4 cycles, rnd_valid=1, res_ready=1 -> grants 01,10,01,10; results emerge in same order, one per cycle.
REQ-034 Randomness starvation: req_valid=01, rnd_valid=0 for 3 cycles -> req_ready=00 and rnd_ready=0 throughout; first accept in cycle rnd_valid rises.
REQ-035 Backpressure: res_ready=0, continuous requests -> exactly DEPTH accepts, then req_ready=00; raising res_ready resumes accepts, no result lost or duplicated.
REQ-036 Reset mid-flight: assert rst_n low one cycle after two accepts -> res_valid=0 after release, FIFO empty, busy=0, next contention grants requester 0 first.
REQ-037 Random sweep: 10k ops with random shares, rnd and res_ready -> every result XOR matches the unmasked AND and its id.
